// File: rtl/trace_uart_tap.sv
// rtl/trace_uart_tap.sv - trace tap: captures CPU state on PC change and streams
// 5-byte 8N1 records (A5, PC, INSTR hi, INSTR lo, flags) out of a UART pin
module trace_uart_tap #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_W       = 3
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_EN,
    input  logic [7:0]        i_PC,
    input  logic [15:0]       i_INSTR,
    input  logic              i_Z,
    input  logic              i_S,
    input  logic              i_C,
    input  logic              i_OF,
    output logic              o_TX,
    output logic              o_BUSY,
    output logic [ADDR_W:0]   o_LEVEL,
    output logic              o_OVF,
    output logic [7:0]        o_DROP_CNT
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]   T_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0] LVL_ONE  = (ADDR_W + 1)'(1);

    logic [31:0]       mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level;
    logic [7:0]        last_pc;
    logic              last_pc_valid;
    logic              ovf;
    logic [7:0]        drop_cnt;

    logic [1:0]        state;
    logic [TW-1:0]     timer;
    logic [2:0]        bit_idx;
    logic [2:0]        byte_idx;
    logic [39:0]       shift;
    logic              tx;

    logic              capture;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;
    logic [31:0]       record;
    logic [31:0]       head;

    assign capture = i_EN && (!last_pc_valid || (i_PC != last_pc));
    assign full    = (level == LVL_FULL);
    assign pop     = (state == S_IDLE) && (level != '0);
    // A full FIFO still accepts a push when the same edge frees a slot.
    assign push    = capture && (!full || pop);
    assign drop    = capture && !push;
    assign record  = {i_PC, i_INSTR, 4'b0000, i_Z, i_S, i_C, i_OF};
    assign head    = mem[rd_ptr];

    always_ff @(posedge i_CLK) begin
        if (push) begin
            mem[wr_ptr] <= record;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            last_pc       <= '0;
            last_pc_valid <= 1'b0;
            ovf           <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            if (capture) begin
                last_pc       <= i_PC;
                last_pc_valid <= 1'b1;
            end else if (!i_EN) begin
                last_pc_valid <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + LVL_ONE;
            end else if (pop && !push) begin
                level <= level - LVL_ONE;
            end
            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    // Shift register holds the whole frame, sync byte lowest, so DATA just
    // streams bit 0 out and shifts right once per bit period.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state    <= S_IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift    <= {head[7:0], head[15:8], head[23:16], head[31:24], 8'hA5};
                        timer    <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    tx <= 1'b0;
                    if (timer == T_LAST) begin
                        timer <= '0;
                        state <= S_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DATA: begin
                    tx <= shift[0];
                    if (timer == T_LAST) begin
                        timer <= '0;
                        shift <= {1'b0, shift[39:1]};
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    tx <= 1'b1;
                    if (timer == T_LAST) begin
                        timer <= '0;
                        if (byte_idx == 3'd4) begin
                            state <= S_IDLE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= S_START;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_TX       = tx;
    assign o_BUSY     = (state != S_IDLE) || (level != '0);
    assign o_LEVEL    = level;
    assign o_OVF      = ovf;
    assign o_DROP_CNT = drop_cnt;

endmodule

// File: tb/tb_trace_uart_tap.sv
// tb/tb_trace_uart_tap.sv - directed bench for trace_uart_tap with a UART
// receiver that logs every byte and its start cycle
module tb_trace_uart_tap;

    localparam int CPB = 4;

    logic        i_CLK = 1'b0;
    logic        i_RST = 1'b0;
    logic        i_EN = 1'b0;
    logic [7:0]  i_PC = 8'h00;
    logic [15:0] i_INSTR = 16'h0000;
    logic        i_Z = 1'b0;
    logic        i_S = 1'b0;
    logic        i_C = 1'b0;
    logic        i_OF = 1'b0;
    logic        o_TX;
    logic        o_BUSY;
    logic [3:0]  o_LEVEL;
    logic        o_OVF;
    logic [7:0]  o_DROP_CNT;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int ferr = 0;
    logic [7:0] rx_q[$];
    int         rx_t[$];

    always #5 i_CLK = ~i_CLK;
    always @(posedge i_CLK) cyc <= cyc + 1;

    trace_uart_tap #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (8),
        .ADDR_W      (3)
    ) dut (
        .i_CLK     (i_CLK),
        .i_RST     (i_RST),
        .i_EN      (i_EN),
        .i_PC      (i_PC),
        .i_INSTR   (i_INSTR),
        .i_Z       (i_Z),
        .i_S       (i_S),
        .i_C       (i_C),
        .i_OF      (i_OF),
        .o_TX      (o_TX),
        .o_BUSY    (o_BUSY),
        .o_LEVEL   (o_LEVEL),
        .o_OVF     (o_OVF),
        .o_DROP_CNT(o_DROP_CNT)
    );

    // Receiver: samples mid-bit on falling clock edges.
    initial begin : rx_mon
        logic       prev;
        logic [7:0] b;
        int         s;
        prev = 1'b1;
        forever begin
            @(negedge i_CLK);
            if (prev && !o_TX) begin
                s = cyc;
                repeat (CPB / 2) @(negedge i_CLK);
                if (o_TX !== 1'b0) ferr++;
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge i_CLK);
                    b[k] = o_TX;
                end
                repeat (CPB) @(negedge i_CLK);
                if (o_TX !== 1'b1) ferr++;
                rx_q.push_back(b);
                rx_t.push_back(s);
            end
            prev = o_TX;
        end
    end

    task automatic do_reset();
        @(negedge i_CLK);
        i_RST = 1'b0;
        repeat (3) @(negedge i_CLK);
        rx_q.delete();
        rx_t.delete();
        ferr = 0;
        i_RST = 1'b1;
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge i_CLK);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge i_CLK);
        nvec++; if (o_TX !== 1'b1) begin nerr++; $display("FAIL reset_tx got %b want 1", o_TX); end
        nvec++; if (o_BUSY !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", o_BUSY); end
        nvec++; if (o_LEVEL !== 4'd0) begin nerr++; $display("FAIL reset_level got %0d want 0", o_LEVEL); end
        nvec++; if (o_OVF !== 1'b0) begin nerr++; $display("FAIL reset_ovf got %b want 0", o_OVF); end
        nvec++; if (o_DROP_CNT !== 8'd0) begin nerr++; $display("FAIL reset_drop got %0d want 0", o_DROP_CNT); end
    endtask

    task automatic test_single_frame();
        logic [7:0] exp_b [5];
        int n;
        exp_b = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h0A};
        i_PC = 8'h00; i_INSTR = 16'h1234;
        i_Z = 1'b1; i_S = 1'b0; i_C = 1'b1; i_OF = 1'b0;
        i_EN = 1'b1;
        i_RST = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge i_CLK);
            if (o_TX === 1'b0) begin n = i; break; end
        end
        nvec++; if (n != 3) begin nerr++; $display("FAIL single_tx_fall_edge got %0d want 3", n); end
        repeat (198) @(negedge i_CLK);
        nvec++; if (o_BUSY !== 1'b1) begin nerr++; $display("FAIL single_busy_in_frame got %b want 1", o_BUSY); end
        repeat (2) @(negedge i_CLK);
        nvec++; if (o_BUSY !== 1'b0) begin nerr++; $display("FAIL single_busy_after got %b want 0", o_BUSY); end
        nvec++; if (rx_q.size() != 5) begin nerr++; $display("FAIL single_byte_count got %0d want 5", rx_q.size()); end
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if (rx_q.size() <= i || rx_q[i] !== exp_b[i]) begin
                nerr++; $display("FAIL single_byte%0d got %h want %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp_b[i]);
            end
        end
        nvec++; if (rx_t.size() >= 2 && rx_t[1] - rx_t[0] != 10 * CPB) begin
            nerr++; $display("FAIL single_byte_spacing got %0d want %0d", rx_t[1] - rx_t[0], 10 * CPB);
        end
        nvec++; if (ferr != 0) begin nerr++; $display("FAIL single_framing got %0d want 0", ferr); end
    endtask

    task automatic test_hold_pc();
        int maxlvl = 0;
        int lows = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge i_CLK);
            if (o_LEVEL > maxlvl) maxlvl = o_LEVEL;
            if (o_TX !== 1'b1) lows++;
        end
        nvec++; if (rx_q.size() != 5) begin nerr++; $display("FAIL hold_byte_count got %0d want 5", rx_q.size()); end
        nvec++; if (maxlvl != 0) begin nerr++; $display("FAIL hold_level got %0d want 0", maxlvl); end
        nvec++; if (lows != 0) begin nerr++; $display("FAIL hold_tx_low_cycles got %0d want 0", lows); end
    endtask

    task automatic test_back_to_back();
        int maxlvl = 0;
        rx_q.delete();
        rx_t.delete();
        @(negedge i_CLK); i_EN = 1'b0;
        @(negedge i_CLK); i_EN = 1'b1; i_PC = 8'h00;
        @(negedge i_CLK); i_PC = 8'h01;
        if (o_LEVEL > maxlvl) maxlvl = o_LEVEL;
        @(negedge i_CLK); i_PC = 8'h02;
        if (o_LEVEL > maxlvl) maxlvl = o_LEVEL;
        for (int i = 0; i < 1000 && rx_q.size() < 15; i++) begin
            @(negedge i_CLK);
            if (o_LEVEL > maxlvl) maxlvl = o_LEVEL;
        end
        nvec++; if (maxlvl != 2) begin nerr++; $display("FAIL b2b_level_peak got %0d want 2", maxlvl); end
        nvec++; if (rx_q.size() != 15) begin nerr++; $display("FAIL b2b_byte_count got %0d want 15", rx_q.size()); end
        for (int f = 0; f < 3; f++) begin
            nvec++;
            if (rx_q.size() < 15 || rx_q[5*f] !== 8'hA5 || rx_q[5*f+1] !== 8'(f)) begin
                nerr++; $display("FAIL b2b_frame%0d_pc got %h want %h", f, (rx_q.size() >= 15) ? rx_q[5*f+1] : 8'hxx, 8'(f));
            end
        end
        for (int f = 1; f < 3; f++) begin
            nvec++;
            if (rx_t.size() < 15 || rx_t[5*f] - rx_t[5*f-1] != 10 * CPB + 1) begin
                nerr++; $display("FAIL b2b_gap%0d got %0d want %0d", f, (rx_t.size() >= 15) ? rx_t[5*f] - rx_t[5*f-1] : -1, 10 * CPB + 1);
            end
        end
        nvec++; if (ferr != 0) begin nerr++; $display("FAIL b2b_framing got %0d want 0", ferr); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_pc [10];
        int maxlvl = 0;
        exp_pc = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h40};
        i_EN = 1'b0;
        do_reset();
        @(negedge i_CLK); i_EN = 1'b1; i_PC = 8'h10;
        for (int k = 1; k < 20; k++) begin
            @(negedge i_CLK);
            if (o_LEVEL > maxlvl) maxlvl = o_LEVEL;
            i_PC = 8'h10 + 8'(k);
        end
        @(negedge i_CLK);
        nvec++; if (o_LEVEL !== 4'd8) begin nerr++; $display("FAIL ovf_level_sat got %0d want 8", o_LEVEL); end
        nvec++; if (o_OVF !== 1'b1) begin nerr++; $display("FAIL ovf_sticky got %b want 1", o_OVF); end
        nvec++; if (o_DROP_CNT !== 8'd11) begin nerr++; $display("FAIL ovf_drop_cnt got %0d want 11", o_DROP_CNT); end
        nvec++; if (maxlvl > 8) begin nerr++; $display("FAIL ovf_level_max got %0d want 8", maxlvl); end
        // the first frame's pop lands on the 202nd edge after the first capture
        repeat (182) @(negedge i_CLK);
        nvec++; if (o_LEVEL !== 4'd8) begin nerr++; $display("FAIL pushpop_level_before got %0d want 8", o_LEVEL); end
        i_PC = 8'h40;
        @(negedge i_CLK);
        nvec++; if (o_LEVEL !== 4'd8) begin nerr++; $display("FAIL pushpop_level_after got %0d want 8", o_LEVEL); end
        nvec++; if (o_DROP_CNT !== 8'd11) begin nerr++; $display("FAIL pushpop_drop_cnt got %0d want 11", o_DROP_CNT); end
        wait_rx(50, 2200);
        nvec++; if (rx_q.size() != 50) begin nerr++; $display("FAIL ovf_byte_count got %0d want 50", rx_q.size()); end
        for (int f = 0; f < 10; f++) begin
            nvec++;
            if (rx_q.size() < 50 || rx_q[5*f] !== 8'hA5 || rx_q[5*f+1] !== exp_pc[f]) begin
                nerr++; $display("FAIL ovf_frame%0d_pc got %h want %h", f, (rx_q.size() >= 50) ? rx_q[5*f+1] : 8'hxx, exp_pc[f]);
            end
        end
        nvec++; if (ferr != 0) begin nerr++; $display("FAIL ovf_framing got %0d want 0", ferr); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp_b [5];
        int n;
        exp_b = '{8'hA5, 8'h6B, 8'hBE, 8'hEF, 8'h07};
        i_EN = 1'b0;
        do_reset();
        @(negedge i_CLK);
        i_EN = 1'b1; i_PC = 8'h60; i_INSTR = 16'hBEEF;
        i_Z = 1'b0; i_S = 1'b1; i_C = 1'b1; i_OF = 1'b1;
        for (int k = 1; k < 12; k++) begin
            @(negedge i_CLK);
            i_PC = 8'h60 + 8'(k);
        end
        // frame started 3 cycles after the first capture; land mid byte 2 data
        repeat (87) @(negedge i_CLK);
        nvec++; if (o_OVF !== 1'b1 || o_LEVEL !== 4'd8) begin
            nerr++; $display("FAIL midrst_pre got ovf=%b level=%0d want ovf=1 level=8", o_OVF, o_LEVEL);
        end
        i_RST = 1'b0;
        #1;
        nvec++; if (o_TX !== 1'b1) begin nerr++; $display("FAIL midrst_tx got %b want 1", o_TX); end
        nvec++; if (o_LEVEL !== 4'd0) begin nerr++; $display("FAIL midrst_level got %0d want 0", o_LEVEL); end
        nvec++; if (o_OVF !== 1'b0) begin nerr++; $display("FAIL midrst_ovf got %b want 0", o_OVF); end
        nvec++; if (o_DROP_CNT !== 8'd0) begin nerr++; $display("FAIL midrst_drop got %0d want 0", o_DROP_CNT); end
        nvec++; if (o_BUSY !== 1'b0) begin nerr++; $display("FAIL midrst_busy got %b want 0", o_BUSY); end
        repeat (50) @(negedge i_CLK);
        rx_q.delete();
        rx_t.delete();
        ferr = 0;
        i_RST = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge i_CLK);
            if (o_TX === 1'b0) begin n = i; break; end
        end
        nvec++; if (n != 3) begin nerr++; $display("FAIL midrst_recapture_edge got %0d want 3", n); end
        wait_rx(5, 300);
        nvec++; if (rx_q.size() != 5) begin nerr++; $display("FAIL midrst_byte_count got %0d want 5", rx_q.size()); end
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if (rx_q.size() <= i || rx_q[i] !== exp_b[i]) begin
                nerr++; $display("FAIL midrst_byte%0d got %h want %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp_b[i]);
            end
        end
        nvec++; if (ferr != 0) begin nerr++; $display("FAIL midrst_framing got %0d want 0", ferr); end
        nvec++; if (o_DROP_CNT !== 8'd0) begin nerr++; $display("FAIL midrst_drop_after got %0d want 0", o_DROP_CNT); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_hold_pc();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
